// File: rtl/sd_arb_pkg.sv
// Shared definitions for the SD sector arbiter: FSM encoding, client/sector sizing
// and the modulo helper used by the round-robin search.
package sd_arb_pkg;

  localparam int MAX_CLI  = 6;
  localparam int SECTOR_W = 32;
  localparam int IDX_W    = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } arb_state_t;

  // (base + step) mod ncli, valid for base < ncli and step <= ncli
  function automatic logic [IDX_W-1:0] rr_wrap(input logic [IDX_W-1:0] base,
                                               input int step, input int ncli);
    int sum;
    sum = int'({29'd0, base}) + step;
    if (sum >= ncli) sum = sum - ncli;
    return IDX_W'(sum);
  endfunction

endpackage

// File: rtl/sd_arb_rr.sv
// Combinational round-robin picker: first requesting client after i_last,
// wrapping modulo NCLI.
module sd_arb_rr import sd_arb_pkg::*; #(
  parameter int NCLI = 6
) (
  input  logic [MAX_CLI-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last,
  output logic [IDX_W-1:0]   o_grant,
  output logic               o_valid
);

  always_comb begin
    o_grant = '0;
    o_valid = 1'b0;
    // Walk from the farthest candidate to the nearest so the nearest hit wins.
    for (int k = NCLI; k >= 1; k--) begin
      if (i_req[rr_wrap(i_last, k, NCLI)]) begin
        o_grant = rr_wrap(i_last, k, NCLI);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sd_sector_arbiter.sv
// Round-robin arbiter granting up to six sector clients exclusive use of one SD card
// wrapper. Optional BUSY watchdog enabled by defining SD_ARB_TIMEOUT_EN.
module sd_sector_arbiter import sd_arb_pkg::*; #(
  parameter int          NCLI           = 6,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd16777215
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCLI-1:0]          cl_rreq,
  input  logic [NCLI-1:0]          cl_wreq,
  input  logic [SECTOR_W*NCLI-1:0] cl_sector,
  input  logic [8*NCLI-1:0]        cl_inbyte,
  output logic [NCLI-1:0]          cl_busy,
  output logic [NCLI-1:0]          cl_ack,
  output logic [NCLI-1:0]          cl_err,
  output logic [NCLI-1:0]          cl_outen,
  output logic [MAX_CLI-1:0]       sd_rstart,
  output logic [MAX_CLI-1:0]       sd_wstart,
  output logic [SECTOR_W-1:0]      sd_rsector,
  input  logic                     sd_rbusy,
  input  logic                     sd_rdone,
  input  logic                     sd_outen,
  input  logic [8:0]               sd_outaddr,
  input  logic [7:0]               sd_outbyte,
  output logic [7:0]               sd_inbyte
);

  localparam logic [IDX_W-1:0]   LAST_RST = IDX_W'(NCLI - 1);
  localparam logic [MAX_CLI-1:0] CLI_MASK = MAX_CLI'((1 << NCLI) - 1);

  arb_state_t           r_state;
  arb_state_t           w_state_next;
  logic [IDX_W-1:0]     r_grant;
  logic [IDX_W-1:0]     r_last;
  logic [SECTOR_W-1:0]  r_sector;
  logic                 r_read;
  logic [IDX_W-1:0]     w_grant;
  logic                 w_valid;
  logic                 w_timeout_hit;
  logic [MAX_CLI-1:0]   w_req;
  logic [MAX_CLI-1:0]   w_rreq;
  logic [MAX_CLI-1:0]   w_onehot;
  logic [SECTOR_W-1:0]  w_sector_arr [MAX_CLI];
  logic [7:0]           w_inbyte_arr [MAX_CLI];

  // Pad client buses to MAX_CLI so a 3-bit grant index is always in range.
  generate
    for (genvar gi = 0; gi < MAX_CLI; gi++) begin : g_cli
      if (gi < NCLI) begin : g_live
        assign w_req[gi]        = cl_rreq[gi] | cl_wreq[gi];
        assign w_rreq[gi]       = cl_rreq[gi];
        assign w_sector_arr[gi] = cl_sector[SECTOR_W*gi +: SECTOR_W];
        assign w_inbyte_arr[gi] = cl_inbyte[8*gi +: 8];
      end else begin : g_pad
        assign w_req[gi]        = 1'b0;
        assign w_rreq[gi]       = 1'b0;
        assign w_sector_arr[gi] = '0;
        assign w_inbyte_arr[gi] = '0;
      end
    end
  endgenerate

  sd_arb_rr #(.NCLI(NCLI)) u_rr (
    .i_req   (w_req),
    .i_last  (r_last),
    .o_grant (w_grant),
    .o_valid (w_valid)
  );

  assign w_onehot   = MAX_CLI'(1) << r_grant;
  assign sd_rsector = r_sector;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_last   <= LAST_RST;
      r_grant  <= '0;
      r_sector <= '0;
      r_read   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == IDLE && w_valid) begin
        r_grant  <= w_grant;
        r_last   <= w_grant;
        r_sector <= w_sector_arr[w_grant];
        r_read   <= w_rreq[w_grant];
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    sd_rstart    = '0;
    sd_wstart    = '0;
    cl_busy      = '0;
    cl_ack       = '0;
    cl_outen     = '0;
    sd_inbyte    = 8'h00;
    unique case (r_state)
      IDLE: begin
        if (w_valid) w_state_next = BUSY;
      end
      BUSY: begin
        if (sd_rdone || w_timeout_hit) w_state_next = ACK;
        if (r_read) sd_rstart = w_onehot & CLI_MASK;
        else        sd_wstart = w_onehot & CLI_MASK;
        cl_busy   = w_onehot[NCLI-1:0];
        if (sd_outen && r_read) cl_outen = w_onehot[NCLI-1:0];
        sd_inbyte = w_inbyte_arr[r_grant];
      end
      ACK: begin
        w_state_next = IDLE;
        cl_busy      = w_onehot[NCLI-1:0];
        cl_ack       = w_onehot[NCLI-1:0];
      end
      default: w_state_next = IDLE;
    endcase
  end

`ifdef SD_ARB_TIMEOUT_EN
  logic [23:0] r_timer;
  logic        r_err;
  logic        w_unused_inputs;

  assign w_timeout_hit   = (r_state == BUSY) && (r_timer == TIMEOUT_CYCLES - 24'd1);
  assign w_unused_inputs = ^{sd_rbusy, sd_outaddr, sd_outbyte};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer <= '0;
      r_err   <= 1'b0;
    end else begin
      r_timer <= (r_state == BUSY) ? r_timer + 24'd1 : 24'd0;
      // A real sd_rdone on the expiry cycle still counts as a clean completion.
      if (r_state == BUSY) r_err <= w_timeout_hit && !sd_rdone;
    end
  end

  assign cl_err = (r_state == ACK && r_err) ? w_onehot[NCLI-1:0] : '0;
`else
  logic w_unused_inputs;

  assign w_timeout_hit   = 1'b0;
  assign w_unused_inputs = ^{sd_rbusy, sd_outaddr, sd_outbyte, TIMEOUT_CYCLES};
  assign cl_err          = '0;
`endif

endmodule

// File: tb/tb_sd_sector_arbiter.sv
// Directed plus randomized check of sd_sector_arbiter against a transaction-level
// round-robin model; the watchdog case runs only when SD_ARB_TIMEOUT_EN is defined.
module tb_sd_sector_arbiter;

  localparam int NCLI = 6;
`ifdef SD_ARB_TIMEOUT_EN
  localparam int N_STROBE = 40;
`else
  localparam int N_STROBE = 512;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [NCLI-1:0]   cl_rreq, cl_wreq;
  logic [32*NCLI-1:0] cl_sector;
  logic [8*NCLI-1:0] cl_inbyte;
  logic [NCLI-1:0]   cl_busy, cl_ack, cl_err, cl_outen;
  logic [5:0]        sd_rstart, sd_wstart;
  logic [31:0]       sd_rsector;
  logic              sd_rbusy, sd_rdone, sd_outen;
  logic [8:0]        sd_outaddr;
  logic [7:0]        sd_outbyte, sd_inbyte;

  int n_cmp = 0;
  int n_err = 0;
  int m_last;
  int n_txn = 0;

  sd_sector_arbiter #(.NCLI(NCLI), .TIMEOUT_CYCLES(24'd100)) dut (
    .clk(clk), .rst(rst),
    .cl_rreq(cl_rreq), .cl_wreq(cl_wreq), .cl_sector(cl_sector), .cl_inbyte(cl_inbyte),
    .cl_busy(cl_busy), .cl_ack(cl_ack), .cl_err(cl_err), .cl_outen(cl_outen),
    .sd_rstart(sd_rstart), .sd_wstart(sd_wstart), .sd_rsector(sd_rsector),
    .sd_rbusy(sd_rbusy), .sd_rdone(sd_rdone), .sd_outen(sd_outen),
    .sd_outaddr(sd_outaddr), .sd_outbyte(sd_outbyte), .sd_inbyte(sd_inbyte)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] onehot(input int g);
    return 6'(1 << g);
  endfunction

  // Reference rule: first requester after the previous grant, wrapping at NCLI.
  function automatic int rr_pick(input logic [5:0] req, input int last);
    for (int d = 1; d <= NCLI; d++) begin
      if (req[(last + d) % NCLI]) return (last + d) % NCLI;
    end
    return -1;
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_rstart"}, sd_rstart, 0);
    chk({tag, "_wstart"}, sd_wstart, 0);
    chk({tag, "_busy"},   cl_busy, 0);
    chk({tag, "_ack"},    cl_ack, 0);
    chk({tag, "_err"},    cl_err, 0);
    chk({tag, "_outen"},  cl_outen, 0);
    chk({tag, "_sector"}, sd_rsector, 0);
    chk({tag, "_inbyte"}, sd_inbyte, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; cl_rreq = '0; cl_wreq = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    m_last = NCLI - 1;
  endtask

  task automatic randomize_data();
    for (int c = 0; c < NCLI; c++) begin
      cl_sector[32*c +: 32] = $urandom;
      cl_inbyte[8*c +: 8]   = 8'($urandom);
    end
  endtask

  // Entered in IDLE at posedge+1 with requests already driven; leaves in IDLE at posedge+1.
  task automatic txn(input int nbusy, input int npulse, input bit drop_mid,
                     input bit keep_req, input bit stray, output int obs_g);
    logic [5:0]  req, oh;
    logic [31:0] sec;
    int g, strobes, bad, sent;
    bit rd;
    chk("idle_rstart", sd_rstart, 0);
    chk("idle_wstart", sd_wstart, 0);
    chk("idle_busy", cl_busy, 0);
    req = 6'(cl_rreq | cl_wreq);
    g = rr_pick(req, m_last);
    if (g < 0) $fatal(1, "FAIL stimulus: empty request vector");
    rd  = cl_rreq[g];
    sec = cl_sector[32*g +: 32];
    oh  = onehot(g);
    sd_rdone = stray;
    @(posedge clk); #1;
    sd_rdone = 1'b0;
    obs_g = -1;
    for (int i = 0; i < NCLI; i++) if (cl_busy[i]) obs_g = i;
    chk("grant_busy", cl_busy, oh);
    chk("grant_rstart", sd_rstart, rd ? oh : 6'h0);
    chk("grant_wstart", sd_wstart, rd ? 6'h0 : oh);
    chk("grant_sector", sd_rsector, sec);
    chk("grant_inbyte", sd_inbyte, cl_inbyte[8*g +: 8]);
    chk("grant_noack", cl_ack, 0);
    strobes = 0; bad = 0; sent = 0;
    for (int i = 0; i < nbusy; i++) begin
      sd_outen = (i % 2 == 1) && (sent < npulse);
      if (sd_outen) begin sd_outaddr = 9'(sent); sent++; end
      sd_outbyte = 8'($urandom);
      randomize_data();
      if (drop_mid && i == 0) begin cl_rreq[g] = 1'b0; cl_wreq[g] = 1'b0; end
      #1;
      if (cl_outen[g]) strobes++;
      if ((cl_outen & ~oh) != 0) bad++;
      if (sd_rsector !== sec) bad++;
      if (sd_inbyte !== cl_inbyte[8*g +: 8]) bad++;
      if (sd_rstart !== (rd ? oh : 6'h0) || sd_wstart !== (rd ? 6'h0 : oh)) bad++;
      if (cl_ack !== 0 || cl_busy !== oh) bad++;
      @(posedge clk); #1;
    end
    chk("outen_strobes", strobes, rd ? npulse : 0);
    chk("busy_hold", bad, 0);
    sd_outen = 1'b0; sd_rdone = 1'b1;
    @(posedge clk); #1;
    sd_rdone = stray;
    chk("ack_pulse", cl_ack, oh);
    chk("ack_err", cl_err, 0);
    chk("ack_rstart", sd_rstart, 0);
    chk("ack_wstart", sd_wstart, 0);
    chk("ack_busy", cl_busy, oh);
    chk("ack_inbyte", sd_inbyte, 0);
    if (!keep_req) begin cl_rreq[g] = 1'b0; cl_wreq[g] = 1'b0; end
    @(posedge clk); #1;
    sd_rdone = 1'b0;
    chk("gap_ack", cl_ack, 0);
    chk("gap_rstart", sd_rstart, 0);
    chk("gap_wstart", sd_wstart, 0);
    chk("gap_busy", cl_busy, 0);
    m_last = g;
    n_txn++;
    $display("txn %0d: client %0d %s sector %h busy %0d obs_client %0d",
             n_txn, g, rd ? "read" : "write", sec, nbusy + 1, obs_g);
  endtask

  initial begin
    int og, g, n, nb;
    rst = 1'b1; cl_rreq = '0; cl_wreq = '0; cl_sector = '0; cl_inbyte = '0;
    sd_rbusy = 1'b0; sd_rdone = 1'b0; sd_outen = 1'b0; sd_outaddr = '0; sd_outbyte = '0;
    m_last = NCLI - 1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("por");
    rst = 1'b0;

    // Single read for client 2.
    cl_sector[2*32 +: 32] = 32'h0000_1234;
    cl_rreq[2] = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    chk("c2_rstart", sd_rstart, 6'b000100);
    chk("c2_sector", sd_rsector, 32'h0000_1234);
    sd_rdone = 1'b1;
    @(posedge clk); #1;
    sd_rdone = 1'b0;
    chk("c2_ack", cl_ack, 6'b000100);
    chk("c2_ack_start", sd_rstart, 0);
    cl_rreq[2] = 1'b0;
    @(posedge clk); #1;
    chk("c2_ack_done", cl_ack, 0);
    m_last = 2;

    // Read wins when both directions are requested.
    cl_rreq[0] = 1'b1; cl_wreq[0] = 1'b1;
    txn(2, 0, 0, 0, 0, og);
    chk("both_client", og, 0);

    // Held requests on 0,3,5 rotate 0,3,5,0.
    do_reset();
    cl_rreq = 6'b101001;
    txn(1, 0, 0, 1, 0, og); chk("rr_order0", og, 0);
    txn(1, 0, 0, 1, 0, og); chk("rr_order1", og, 3);
    txn(1, 0, 0, 1, 0, og); chk("rr_order2", og, 5);
    txn(1, 0, 0, 1, 0, og); chk("rr_order3", og, 0);
    cl_rreq = '0;
    @(posedge clk); #1;

    // Read strobes for client 1, then a write from client 4.
    cl_rreq[1] = 1'b1;
    txn(2 * N_STROBE + 1, N_STROBE, 0, 0, 0, og);
    chk("strobe_client", og, 1);
    cl_wreq[4] = 1'b1; cl_inbyte[4*8 +: 8] = 8'hA5;
    txn(3, 1, 0, 0, 0, og);
    chk("write_client", og, 4);

    // Reset in the middle of BUSY.
    cl_rreq[3] = 1'b1;
    g = rr_pick(6'(cl_rreq | cl_wreq), m_last);
    @(posedge clk); #1;
    chk("pre_rst_busy", cl_busy, onehot(g));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_all_zero("mid_rst");
    @(posedge clk); #1;
    chk("mid_rst_noack", cl_ack, 0);
    rst = 1'b0; m_last = NCLI - 1;
    cl_rreq = 6'b011101;
    txn(1, 0, 0, 0, 0, og);
    chk("post_rst_first", og, 0);
    cl_rreq = '0;

`ifdef SD_ARB_TIMEOUT_EN
    cl_rreq[3] = 1'b1;
    g = rr_pick(6'(cl_rreq | cl_wreq), m_last);
    @(posedge clk); #1;
    n = 0;
    while (cl_ack == 0 && n < 200) begin @(posedge clk); #1; n++; end
    chk("timeout_cycles", n, 100);
    chk("timeout_ack", cl_ack, onehot(g));
    chk("timeout_err", cl_err, onehot(g));
    cl_rreq[3] = 1'b0;
    @(posedge clk); #1;
    chk("timeout_err_clear", cl_err, 0);
    m_last = g;
    $display("txn timeout: client %0d after %0d cycles", g, n);
`endif

    // Randomized traffic with stray sd_rdone and mid-transaction request drops.
    for (int t = 0; t < 40; t++) begin
      randomize_data();
      cl_rreq = cl_rreq | (6'($urandom) & 6'($urandom));
      cl_wreq = cl_wreq | (6'($urandom) & 6'($urandom));
      if ((cl_rreq | cl_wreq) == 0) cl_rreq[$urandom_range(0, NCLI-1)] = 1'b1;
      nb = $urandom_range(0, 6);
      txn(nb, nb / 2, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), og);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
